// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator.
// State encoding, result encoding and counter sizing.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result bits ordered {less, greater, equal}
  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_GT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  // Bit counter width, never narrower than one bit
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Operand and result handshakes of the serial comparator.
// master: operand source / result consumer; slave: comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             less;
  logic             greater;
  logic             equal;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  less,
    input  greater,
    input  equal
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output less,
    output greater,
    output equal
  );

endinterface

// File: rtl/bit_compare_cell.sv
// Gate-level 1-bit magnitude compare cell.
// Ports: x, y in; lt = x<y, gt = x>y, eq = x==y.
module bit_compare_cell (
  input  logic x,
  input  logic y,
  output logic lt,
  output logic gt,
  output logic eq
);

  logic xn;
  logic yn;

  not  u_inv_x (xn, x);
  not  u_inv_y (yn, y);
  and  u_and_lt (lt, xn, y);
  and  u_and_gt (gt, x, yn);
  xnor u_xnor_eq (eq, x, y);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator.
// Ports: clk, rst_n, bus (slave: operand in, one-hot result out).
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  serial_magnitude_comparator_if.slave   bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] b_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             decided;
  logic             dec_nxt;
  logic [1:0]       pend;
  logic [1:0]       pend_nxt;
  logic [2:0]       res_q;
  logic [2:0]       res_nxt;

  logic bl;
  logic bg;
  logic be;

  bit_compare_cell u_cell (
    .x  (a_sh[WIDTH-1]),
    .y  (b_sh[WIDTH-1]),
    .lt (bl),
    .gt (bg),
    .eq (be)
  );

  always_comb begin
    state_nxt = state;
    a_nxt     = a_sh;
    b_nxt     = b_sh;
    cnt_nxt   = cnt;
    dec_nxt   = decided;
    pend_nxt  = pend;
    res_nxt   = res_q;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_nxt     = bus.a;
          b_nxt     = bus.b;
          cnt_nxt   = CNT_MAX;
          dec_nxt   = 1'b0;
          pend_nxt  = 2'b00;
          res_nxt   = 3'b000;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // Only the first mismatch counts in full-scan mode
        if (!be && !decided) begin
          dec_nxt  = 1'b1;
          pend_nxt = {bl, bg};
        end
        if (EARLY_EXIT && !be) begin
          res_nxt   = {bl, bg, 1'b0};
          state_nxt = DONE;
        end else if (cnt == '0) begin
          res_nxt   = dec_nxt ? {pend_nxt, 1'b0}
                              : RES_EQ;
          state_nxt = DONE;
        end else begin
          a_nxt   = a_sh << 1;
          b_nxt   = b_sh << 1;
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          res_nxt   = 3'b000;
          state_nxt = IDLE;
        end
      end
      default: begin
        res_nxt   = 3'b000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      pend    <= 2'b00;
      res_q   <= 3'b000;
    end else begin
      state   <= state_nxt;
      a_sh    <= a_nxt;
      b_sh    <= b_nxt;
      cnt     <= cnt_nxt;
      decided <= dec_nxt;
      pend    <= pend_nxt;
      res_q   <= res_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.less      = res_q[2];
  assign bus.greater   = res_q[1];
  assign bus.equal     = res_q[0];

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Compares two WIDTH-bit unsigned operands one bit pair per cycle, MSB first.
- Each bit pair goes through a gate-level 1-bit compare cell. The first mismatching bit decides the result.
- Sits downstream of the operand source: accepts operands on a valid/ready handshake and returns a one-hot less/greater/equal result on a second valid/ready handshake.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..64.
- EARLY_EXIT, 1, if 1 the result is issued on the first mismatching bit; if 0 all WIDTH bits are always scanned (fixed latency).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; single clock domain.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- less  output  1  registered; A < B.
- greater  output  1  registered; A > B.
- equal  output  1  registered; A == B.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - out_valid, less, greater and equal go to 0.
  - Shift registers, counter and decided flag are cleared.
  - in_ready reads 1 once rst_n is released.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - At a clock edge with in_valid = 1, load a_sh <= a, b_sh <= b, cnt <= WIDTH-1, decided <= 0, then go to SHIFT.
  - a and b are sampled only at this accept edge.
- SHIFT, one bit per cycle:
  - The cell compares a_sh[WIDTH-1] with b_sh[WIDTH-1]; cell outputs are bl, bg, be.
  - EARLY_EXIT=1: if be = 0, latch less <= bl and greater <= bg, clear equal, go to DONE.
  - EARLY_EXIT=0: the first be = 0 with decided = 0 latches bl/bg and sets decided; later bits are ignored.
  - If cnt == 0 with no mismatch latched: equal <= 1, go to DONE.
  - If cnt == 0 with a mismatch latched: go to DONE with the latched less/greater.
  - Otherwise: shift a_sh and b_sh left by 1, cnt <= cnt-1.
  - in_ready = 0.
- DONE:
  - out_valid = 1.
  - less, greater and equal are exactly one-hot and held stable while out_ready = 0.
  - At an edge with out_ready = 1: out_valid <= 0, result bits cleared, go to IDLE.
  - One bubble cycle: the next accept happens no earlier than the following edge.
- Latency, with accept edge = E0 and the mismatching bit at index k (MSB = WIDTH-1):
  - out_valid is high after edge E0 + (WIDTH - k) when EARLY_EXIT=1.
  - out_valid is high after edge E0 + WIDTH when EARLY_EXIT=0 or when the operands are equal.
- Boundaries:
  - WIDTH = 1: one SHIFT cycle; the counter is at least 1 bit wide.
  - in_valid while busy: ignored, no buffering.
  - out_ready high outside DONE: ignored.
  - Reset mid-SHIFT or mid-DONE: the result in flight is discarded with no partial output.
- Arithmetic: unsigned only; no sign handling; counter width is $clog2(WIDTH) with a minimum of 1.

Decomposition:
- Shared package cmp_pkg holds:
  - the state enum: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  - the result-encoding constants: RES_LT = 3'b100, RES_GT = 3'b010, RES_EQ = 3'b001, ordered {less, greater, equal}.
- One sub-module, bit_compare_cell:
  - purely gate-level (two inverters, two ANDs, one XNOR);
  - inputs x, y; outputs lt, gt, eq;
  - instantiated once on the shift-register MSBs.
- FSM, counter and shift registers live in the top module.

Test Plan:
- WIDTH=8, EARLY_EXIT=1, a=0xA5, b=0xA5 -> equal=1, less=0, greater=0; out_valid after edge E0+8.
- EARLY_EXIT=1, a=0x80, b=0x7F -> greater=1 after edge E0+1. Same operands with EARLY_EXIT=0 -> greater=1 after edge E0+8.
- a=0x12, b=0x13, either mode -> less=1 after edge E0+8 (mismatch at bit 0).
- Backpressure:
  - Stimulus: a=0x03, b=0xF0, then hold out_ready=0 for 5 cycles and pulse in_valid during that window.
  - Response: less=1 held stable; in_ready=0; the new in_valid is ignored; the result releases on the first out_ready=1 edge and in_ready rises the next cycle.
- Reset mid-SHIFT: assert rst_n=0 for 1 cycle at the third SHIFT cycle -> all outputs 0 immediately (async); in_ready=1 after release; a following a=0x01, b=0x00 returns greater=1.
- Back-to-back with out_ready tied 1, random 200-pair sweep -> matches a reference model.
  - Run at WIDTH=8 and WIDTH=1. Check exactly one result bit high whenever out_valid=1, and exactly one bubble cycle between transactions.
